// File: rtl/cohort_mshr_pool_arbiter_if.sv
// Request/response bus between NUM_SRC source controllers, the MSHR pool arbiter and the NoC2/NoC3 paths.
interface cohort_mshr_pool_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int REQ_W   = 176,
  parameter int DATA_W  = 64
);
  logic [NUM_SRC-1:0]       src_en;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic [NUM_SRC*REQ_W-1:0] src_req;
  logic                     snk_valid;
  logic                     snk_ready;
  logic [REQ_W-1:0]         snk_req;
  logic [7:0]               snk_mshrid;
  logic                     rsp_valid;
  logic [7:0]               rsp_mshrid;
  logic [DATA_W-1:0]        rsp_data;
  logic [NUM_SRC-1:0]       src_rsp_valid;
  logic [DATA_W-1:0]        src_rsp_data;

  modport master (
    output src_en, src_valid, src_req, snk_ready, rsp_valid, rsp_mshrid, rsp_data,
    input  src_ready, snk_valid, snk_req, snk_mshrid, src_rsp_valid, src_rsp_data
  );

  modport slave (
    input  src_en, src_valid, src_req, snk_ready, rsp_valid, rsp_mshrid, rsp_data,
    output src_ready, snk_valid, snk_req, snk_mshrid, src_rsp_valid, src_rsp_data
  );
endinterface

// File: rtl/cohort_mshr_pool_arbiter.sv
// Round-robin N-source arbiter that tags each grant with an MSHR ID from a shared pool and routes responses by owner.
// Optional per-source grant counters are built when COHORT_MSHR_PERF_EN is defined.
module cohort_mshr_pool_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int MSHR_BASE   = 128,
  parameter int MSHR_NUM    = 16,
  parameter int MAX_OUT_SRC = 8,
  parameter int REQ_W       = 176,
  parameter int DATA_W      = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cohort_mshr_pool_arbiter_if.slave bus,
  output logic [6:0]               outstanding,
  output logic                     err_sticky,
  output logic [NUM_SRC*32-1:0]    perf_grants
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SUM_W = SRC_W + 1;
  localparam int IDX_W = $clog2(MSHR_NUM);
  localparam int CNT_W = $clog2(MAX_OUT_SRC + 1);
  localparam logic [8:0] ID_LO = 9'(MSHR_BASE);
  localparam logic [8:0] ID_HI = 9'(MSHR_BASE + MSHR_NUM);

  logic [MSHR_NUM-1:0] free_q;
  logic [SRC_W-1:0]    owner_q [MSHR_NUM];
  logic [CNT_W-1:0]    cnt_q   [NUM_SRC];
  logic [SRC_W-1:0]    rr_q;
  logic                slot_valid_q;
  logic [REQ_W-1:0]    slot_req_q;
  logic [7:0]          slot_id_q;
  logic [NUM_SRC-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic                pool_avail;
  logic                can_load;
  logic                any_elig;
  logic                grant;
  logic [NUM_SRC-1:0]  eligible;
  logic [2*NUM_SRC-1:0] elig_dbl;
  logic [NUM_SRC-1:0]  elig_rot;
  logic [SUM_W-1:0]    rr_sum;
  logic [SRC_W-1:0]    winner;
  logic [SRC_W-1:0]    rr_d;
  logic [REQ_W-1:0]    win_req;
  logic [IDX_W-1:0]    alloc_idx;
  logic                rsp_in_range;
  logic                rsp_hit;
  logic [IDX_W-1:0]    rsp_idx;
  logic [SRC_W-1:0]    rsp_owner;
  logic [MSHR_NUM-1:0] free_d;
  logic [CNT_W-1:0]    cnt_d   [NUM_SRC];
  logic [6:0]          pop_d;

  // A source competes only while it is below its outstanding limit and the pool has an ID left.
  always_comb begin
    pool_avail = |free_q;
    can_load   = !slot_valid_q || bus.snk_ready;
    eligible   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = bus.src_valid[i] && bus.src_en[i] &&
                    (cnt_q[i] < CNT_W'(MAX_OUT_SRC)) && pool_avail;
    end
  end

  always_comb begin
    elig_dbl = {eligible, eligible};
    elig_rot = NUM_SRC'(elig_dbl >> rr_q);
    winner   = '0;
    any_elig = 1'b0;
    rr_sum   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        any_elig = 1'b1;
        rr_sum   = {1'b0, rr_q} + SUM_W'(k);
        if (rr_sum >= SUM_W'(NUM_SRC)) begin
          rr_sum = rr_sum - SUM_W'(NUM_SRC);
        end
        winner = rr_sum[SRC_W-1:0];
      end
    end
    grant = can_load && any_elig;
    rr_d  = rr_q;
    if (grant) begin
      rr_d = (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + SRC_W'(1);
    end
  end

  always_comb begin
    bus.src_ready = '0;
    win_req       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (winner == SRC_W'(i)) begin
        bus.src_ready[i] = grant;
        win_req          = bus.src_req[i*REQ_W +: REQ_W];
      end
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Only IDs inside the pool window that are currently allocated are routed; anything else is an error.
  always_comb begin
    rsp_in_range = ({1'b0, bus.rsp_mshrid} >= ID_LO) && ({1'b0, bus.rsp_mshrid} < ID_HI);
    rsp_idx      = IDX_W'(bus.rsp_mshrid - ID_LO[7:0]);
    rsp_hit      = bus.rsp_valid && rsp_in_range && !free_q[rsp_idx];
    rsp_owner    = owner_q[rsp_idx];
  end

  // The freed and allocated IDs are always different bits, so both updates apply independently.
  always_comb begin
    free_d = free_q;
    if (grant) begin
      free_d[alloc_idx] = 1'b0;
    end
    if (rsp_hit) begin
      free_d[rsp_idx] = 1'b1;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant && (winner == SRC_W'(i))) begin
        cnt_d[i] = cnt_d[i] + CNT_W'(1);
      end
      if (rsp_hit && (rsp_owner == SRC_W'(i))) begin
        cnt_d[i] = cnt_d[i] - CNT_W'(1);
      end
    end
    pop_d = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (!free_d[i]) begin
        pop_d = pop_d + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q       <= '1;
      rr_q         <= '0;
      slot_valid_q <= 1'b0;
      slot_req_q   <= '0;
      slot_id_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      outstanding  <= '0;
      err_sticky   <= 1'b0;
      for (int i = 0; i < MSHR_NUM; i++) begin
        owner_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      free_q      <= free_d;
      outstanding <= pop_d;
      rr_q        <= rr_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (grant) begin
        slot_valid_q       <= 1'b1;
        slot_req_q         <= win_req;
        slot_id_q          <= ID_LO[7:0] + 8'(alloc_idx);
        owner_q[alloc_idx] <= winner;
      end else if (bus.snk_ready) begin
        slot_valid_q <= 1'b0;
      end
      rsp_valid_q <= '0;
      if (rsp_hit) begin
        rsp_valid_q[rsp_owner] <= 1'b1;
        rsp_data_q             <= bus.rsp_data;
      end
      if (bus.rsp_valid && !rsp_hit) begin
        err_sticky <= 1'b1;
      end
    end
  end

  assign bus.snk_valid     = slot_valid_q;
  assign bus.snk_req       = slot_req_q;
  assign bus.snk_mshrid    = slot_id_q;
  assign bus.src_rsp_valid = rsp_valid_q;
  assign bus.src_rsp_data  = rsp_data_q;

`ifdef COHORT_MSHR_PERF_EN
  logic [31:0] perf_q [NUM_SRC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        perf_q[i] <= '0;
      end
    end else if (grant) begin
      perf_q[winner] <= perf_q[winner] + 32'd1;
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      perf_grants[i*32 +: 32] = perf_q[i];
    end
  end
`else
  assign perf_grants = '0;
`endif

endmodule

// File: tb/tb_cohort_mshr_pool_arbiter.sv
// Randomised and directed checks of cohort_mshr_pool_arbiter against a cycle-level reference model.
module tb_cohort_mshr_pool_arbiter;

  localparam int N      = 8;
  localparam int BASE   = 128;
  localparam int MN     = 16;
  localparam int MAXO   = 2;
  localparam int REQ_W  = 176;
  localparam int DATA_W = 64;
`ifdef COHORT_MSHR_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [6:0]      outstanding;
  logic            err_sticky;
  logic [N*32-1:0] perf_grants;
  int total;
  int bad;

  // Reference model: owner per pool slot (-1 = free), per-source counts derived from it.
  int               m_owner [MN];
  int               m_rr;
  bit               m_slot_v;
  int               m_slot_id;
  logic [REQ_W-1:0] m_slot_req;
  logic [N-1:0]     m_rsp_v;
  logic [DATA_W-1:0] m_rsp_data;
  bit               m_err;
  int               m_perf [N];
  logic [N-1:0]     exp_src_ready;
  logic [N-1:0]     obs_src_ready;

  cohort_mshr_pool_arbiter_if #(.NUM_SRC(N), .REQ_W(REQ_W), .DATA_W(DATA_W)) bus ();

  cohort_mshr_pool_arbiter #(
    .NUM_SRC(N), .MSHR_BASE(BASE), .MSHR_NUM(MN), .MAX_OUT_SRC(MAXO), .REQ_W(REQ_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .outstanding(outstanding), .err_sticky(err_sticky), .perf_grants(perf_grants)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int m_cnt(int s);
    int c = 0;
    foreach (m_owner[i]) if (m_owner[i] == s) c++;
    return c;
  endfunction

  function automatic int m_out();
    int c = 0;
    foreach (m_owner[i]) if (m_owner[i] >= 0) c++;
    return c;
  endfunction

  function automatic int m_lowest_alloc();
    for (int i = 0; i < MN; i++) if (m_owner[i] >= 0) return i;
    return -1;
  endfunction

  function automatic logic [REQ_W-1:0] rand_payload();
    logic [REQ_W-1:0] p = '0;
    for (int i = 0; i < 6; i++) p = (p << 32) | REQ_W'($urandom());
    return p;
  endfunction

  task automatic fill_src_req();
    for (int i = 0; i < N; i++) bus.src_req[i*REQ_W +: REQ_W] = rand_payload();
  endtask

  task automatic drive_idle();
    bus.src_en     = '1;
    bus.src_valid  = '0;
    bus.snk_ready  = 1'b1;
    bus.rsp_valid  = 1'b0;
    bus.rsp_mshrid = '0;
    bus.rsp_data   = '0;
    fill_src_req();
  endtask

  task automatic model_reset();
    foreach (m_owner[i]) m_owner[i] = -1;
    foreach (m_perf[i]) m_perf[i] = 0;
    m_rr = 0; m_slot_v = 0; m_slot_id = 0; m_slot_req = '0;
    m_rsp_v = '0; m_rsp_data = '0; m_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Advances one clock: samples src_ready and inputs at the negedge, predicts, then updates after the edge.
  task automatic model_cycle();
    int lf, win, rid, hidx, hown;
    bit hit, rdy, rv;
    logic [REQ_W-1:0] wreq;
    logic [DATA_W-1:0] rdat;
    @(negedge clk);
    obs_src_ready = bus.src_ready;
    rdy = bus.snk_ready;
    rv  = bus.rsp_valid;
    lf = -1;
    for (int i = MN - 1; i >= 0; i--) if (m_owner[i] < 0) lf = i;
    win = -1;
    if ((!m_slot_v || rdy) && lf >= 0) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_rr + k) % N;
        if (win < 0 && bus.src_valid[s] && bus.src_en[s] && m_cnt(s) < MAXO) win = s;
      end
    end
    exp_src_ready = '0;
    wreq = '0;
    if (win >= 0) begin
      exp_src_ready[win] = 1'b1;
      wreq = bus.src_req[win*REQ_W +: REQ_W];
    end
    rid = int'(bus.rsp_mshrid);
    hit = 0; hidx = -1; hown = -1;
    if (rv && rid >= BASE && rid < BASE + MN) begin
      if (m_owner[rid-BASE] >= 0) begin
        hit = 1; hidx = rid - BASE; hown = m_owner[hidx];
      end
    end
    rdat = bus.rsp_data;
    @(posedge clk);
    if (win >= 0) begin
      m_owner[lf] = win; m_slot_v = 1; m_slot_id = BASE + lf; m_slot_req = wreq;
      m_rr = (win + 1) % N; m_perf[win]++;
    end else if (rdy) begin
      m_slot_v = 0;
    end
    m_rsp_v = '0;
    if (hit) begin
      m_rsp_v[hown] = 1'b1; m_rsp_data = rdat; m_owner[hidx] = -1;
    end
    if (rv && !hit) m_err = 1;
    #1;
  endtask

  task automatic test_reset();
    total++; if (bus.snk_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_snk_valid got=%0b exp=0", bus.snk_valid); end
    total++; if (bus.snk_mshrid !== 8'd0) begin bad++; $display("[TB] FAIL reset_snk_mshrid got=%0d exp=0", bus.snk_mshrid); end
    total++; if (bus.src_ready !== '0) begin bad++; $display("[TB] FAIL reset_src_ready got=%0h exp=0", bus.src_ready); end
    total++; if (bus.src_rsp_valid !== '0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%0h exp=0", bus.src_rsp_valid); end
    total++; if (outstanding !== 7'd0) begin bad++; $display("[TB] FAIL reset_outstanding got=%0d exp=0", outstanding); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0b exp=0", err_sticky); end
    total++; if (perf_grants !== '0) begin bad++; $display("[TB] FAIL reset_perf got=%0h exp=0", perf_grants); end
  endtask

  // All sources requesting: strict rotation 0..7 with IDs 128 upward, until the pool is full.
  task automatic test_round_robin();
    logic [REQ_W-1:0] exp_req;
    bus.src_valid = '1;
    for (int c = 0; c < MN; c++) begin
      fill_src_req();
      exp_req = bus.src_req[(c % N)*REQ_W +: REQ_W];
      model_cycle();
      total++; if (obs_src_ready !== (N'(1) << (c % N))) begin bad++; $display("[TB] FAIL rr_src_ready c=%0d got=%0h exp=%0h", c, obs_src_ready, N'(1) << (c % N)); end
      total++; if (bus.snk_mshrid !== 8'(BASE + c)) begin bad++; $display("[TB] FAIL rr_mshrid c=%0d got=%0d exp=%0d", c, bus.snk_mshrid, BASE + c); end
      total++; if (bus.snk_req !== exp_req) begin bad++; $display("[TB] FAIL rr_snk_req c=%0d got=%0h exp=%0h", c, bus.snk_req, exp_req); end
      total++; if (outstanding !== 7'(c + 1)) begin bad++; $display("[TB] FAIL rr_outstanding c=%0d got=%0d exp=%0d", c, outstanding, c + 1); end
    end
    for (int c = 0; c < 2; c++) begin
      model_cycle();
      total++; if (obs_src_ready !== '0) begin bad++; $display("[TB] FAIL full_src_ready got=%0h exp=0", obs_src_ready); end
      total++; if (bus.snk_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_snk_valid got=%0b exp=0", bus.snk_valid); end
      total++; if (outstanding !== 7'd16) begin bad++; $display("[TB] FAIL full_outstanding got=%0d exp=16", outstanding); end
    end
  endtask

  task automatic test_pool_reuse();
    logic [DATA_W-1:0] d;
    d = {$urandom(), $urandom()};
    bus.rsp_valid = 1'b1; bus.rsp_mshrid = 8'd133; bus.rsp_data = d;
    model_cycle();
    bus.rsp_valid = 1'b0;
    total++; if (obs_src_ready !== '0) begin bad++; $display("[TB] FAIL reuse_early_grant got=%0h exp=0", obs_src_ready); end
    total++; if (bus.src_rsp_valid !== 8'b0010_0000) begin bad++; $display("[TB] FAIL reuse_rsp_route got=%0h exp=20", bus.src_rsp_valid); end
    total++; if (bus.src_rsp_data !== d) begin bad++; $display("[TB] FAIL reuse_rsp_data got=%0h exp=%0h", bus.src_rsp_data, d); end
    total++; if (outstanding !== 7'd15) begin bad++; $display("[TB] FAIL reuse_outstanding got=%0d exp=15", outstanding); end
    model_cycle();
    total++; if (obs_src_ready !== 8'b0010_0000) begin bad++; $display("[TB] FAIL reuse_grant got=%0h exp=20", obs_src_ready); end
    total++; if (bus.snk_mshrid !== 8'd133) begin bad++; $display("[TB] FAIL reuse_mshrid got=%0d exp=133", bus.snk_mshrid); end
    total++; if (outstanding !== 7'd16) begin bad++; $display("[TB] FAIL reuse_outstanding2 got=%0d exp=16", outstanding); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    total++; if (outstanding !== 7'd0) begin bad++; $display("[TB] FAIL midrst_outstanding got=%0d exp=0", outstanding); end
    bus.rsp_valid = 1'b1; bus.rsp_mshrid = 8'd130;
    model_cycle();
    bus.rsp_valid = 1'b0;
    total++; if (err_sticky !== 1'b1) begin bad++; $display("[TB] FAIL midrst_err got=%0b exp=1", err_sticky); end
    total++; if (bus.src_rsp_valid !== '0) begin bad++; $display("[TB] FAIL midrst_rsp got=%0h exp=0", bus.src_rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic [REQ_W-1:0] held;
    do_reset();
    bus.src_valid = 8'b0000_0001; bus.snk_ready = 1'b0;
    model_cycle();
    held = bus.src_req[REQ_W-1:0];
    total++; if (obs_src_ready !== 8'b1) begin bad++; $display("[TB] FAIL bp_first_grant got=%0h exp=1", obs_src_ready); end
    for (int c = 0; c < 4; c++) begin
      fill_src_req();
      model_cycle();
      total++; if (obs_src_ready !== '0) begin bad++; $display("[TB] FAIL bp_src_ready c=%0d got=%0h exp=0", c, obs_src_ready); end
      total++; if (bus.snk_valid !== 1'b1 || bus.snk_mshrid !== 8'd128) begin bad++; $display("[TB] FAIL bp_hold c=%0d got=%0b/%0d exp=1/128", c, bus.snk_valid, bus.snk_mshrid); end
      total++; if (bus.snk_req !== held) begin bad++; $display("[TB] FAIL bp_req_stable c=%0d got=%0h exp=%0h", c, bus.snk_req, held); end
      total++; if (outstanding !== 7'd1) begin bad++; $display("[TB] FAIL bp_outstanding c=%0d got=%0d exp=1", c, outstanding); end
    end
    bus.snk_ready = 1'b1;
    model_cycle();
    total++; if (bus.snk_mshrid !== 8'd129 || obs_src_ready !== 8'b1) begin bad++; $display("[TB] FAIL bp_release got=%0d/%0h exp=129/1", bus.snk_mshrid, obs_src_ready); end
    bus.src_valid = '0;
    model_cycle();
    total++; if (bus.snk_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0b exp=0", bus.snk_valid); end
  endtask

  task automatic test_max_out();
    int grants = 0;
    do_reset();
    bus.src_valid = 8'b0000_0010;
    for (int c = 0; c < 6; c++) begin
      model_cycle();
      if (obs_src_ready[1]) grants++;
    end
    total++; if (grants != MAXO) begin bad++; $display("[TB] FAIL maxout_grants got=%0d exp=%0d", grants, MAXO); end
    total++; if (outstanding !== 7'(MAXO)) begin bad++; $display("[TB] FAIL maxout_outstanding got=%0d exp=%0d", outstanding, MAXO); end
    bus.rsp_valid = 1'b1; bus.rsp_mshrid = 8'd128;
    model_cycle();
    bus.rsp_valid = 1'b0;
    total++; if (obs_src_ready !== '0 || bus.src_rsp_valid !== 8'b10) begin bad++; $display("[TB] FAIL maxout_rsp got=%0h/%0h exp=0/2", obs_src_ready, bus.src_rsp_valid); end
    model_cycle();
    total++; if (obs_src_ready !== 8'b10 || bus.snk_mshrid !== 8'd128) begin bad++; $display("[TB] FAIL maxout_resume got=%0h/%0d exp=2/128", obs_src_ready, bus.snk_mshrid); end
  endtask

  task automatic test_stray();
    do_reset();
    bus.src_valid = 8'b0000_0001;
    model_cycle();
    bus.src_valid = '0;
    bus.rsp_valid = 1'b1; bus.rsp_mshrid = 8'd200;
    model_cycle();
    total++; if (err_sticky !== 1'b1 || bus.src_rsp_valid !== '0) begin bad++; $display("[TB] FAIL stray200 got=%0b/%0h exp=1/0", err_sticky, bus.src_rsp_valid); end
    total++; if (outstanding !== 7'd1) begin bad++; $display("[TB] FAIL stray200_outstanding got=%0d exp=1", outstanding); end
    bus.rsp_mshrid = 8'd140;
    model_cycle();
    total++; if (bus.src_rsp_valid !== '0 || outstanding !== 7'd1) begin bad++; $display("[TB] FAIL stray140 got=%0h/%0d exp=0/1", bus.src_rsp_valid, outstanding); end
    bus.rsp_mshrid = 8'd128;
    model_cycle();
    bus.rsp_valid = 1'b0;
    total++; if (bus.src_rsp_valid !== 8'b1 || err_sticky !== 1'b1 || outstanding !== 7'd0) begin bad++; $display("[TB] FAIL stray_legit got=%0h/%0b/%0d exp=1/1/0", bus.src_rsp_valid, err_sticky, outstanding); end
  endtask

  task automatic test_src_en();
    do_reset();
    bus.src_valid = 8'b0000_1000;
    model_cycle();
    bus.src_en = 8'b1111_0111;
    for (int c = 0; c < 3; c++) begin
      model_cycle();
      total++; if (obs_src_ready !== '0) begin bad++; $display("[TB] FAIL en_blocked c=%0d got=%0h exp=0", c, obs_src_ready); end
    end
    bus.rsp_valid = 1'b1; bus.rsp_mshrid = 8'd128;
    model_cycle();
    bus.rsp_valid = 1'b0;
    total++; if (bus.src_rsp_valid !== 8'b0000_1000 || outstanding !== 7'd0) begin bad++; $display("[TB] FAIL en_route got=%0h/%0d exp=8/0", bus.src_rsp_valid, outstanding); end
    bus.src_valid = '0; bus.src_en = '1;
  endtask

  task automatic test_random();
    int q[$];
    int r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fill_src_req();
      bus.src_valid = N'($urandom());
      bus.src_en    = N'($urandom()) | N'($urandom());
      bus.snk_ready = ($urandom_range(3) != 0);
      bus.rsp_data  = {$urandom(), $urandom()};
      q.delete();
      foreach (m_owner[i]) if (m_owner[i] >= 0) q.push_back(i);
      r = int'($urandom_range(99));
      bus.rsp_valid = 1'b0;
      if (r < 40 && q.size() > 0) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_mshrid = 8'(BASE + q[$urandom_range(q.size() - 1)]);
      end else if (r < 45) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_mshrid = 8'($urandom());
      end
      model_cycle();
      total++; if (obs_src_ready !== exp_src_ready) begin bad++; $display("[TB] FAIL rnd_src_ready c=%0d got=%0h exp=%0h", c, obs_src_ready, exp_src_ready); end
      total++; if (bus.snk_valid !== m_slot_v) begin bad++; $display("[TB] FAIL rnd_snk_valid c=%0d got=%0b exp=%0b", c, bus.snk_valid, m_slot_v); end
      if (m_slot_v) begin
        total++; if (bus.snk_mshrid !== 8'(m_slot_id) || bus.snk_req !== m_slot_req) begin bad++; $display("[TB] FAIL rnd_snk_tag c=%0d got=%0d exp=%0d", c, bus.snk_mshrid, m_slot_id); end
      end
      total++; if (bus.src_rsp_valid !== m_rsp_v) begin bad++; $display("[TB] FAIL rnd_rsp_valid c=%0d got=%0h exp=%0h", c, bus.src_rsp_valid, m_rsp_v); end
      if (m_rsp_v != '0) begin
        total++; if (bus.src_rsp_data !== m_rsp_data) begin bad++; $display("[TB] FAIL rnd_rsp_data c=%0d got=%0h exp=%0h", c, bus.src_rsp_data, m_rsp_data); end
      end
      total++; if (outstanding !== 7'(m_out())) begin bad++; $display("[TB] FAIL rnd_outstanding c=%0d got=%0d exp=%0d", c, outstanding, m_out()); end
      total++; if (err_sticky !== m_err) begin bad++; $display("[TB] FAIL rnd_err c=%0d got=%0b exp=%0b", c, err_sticky, m_err); end
    end
    for (int i = 0; i < N; i++) begin
      total++; if (perf_grants[i*32 +: 32] !== (PERF_ON ? 32'(m_perf[i]) : 32'd0)) begin bad++; $display("[TB] FAIL rnd_perf src=%0d got=%0d exp=%0d", i, perf_grants[i*32 +: 32], PERF_ON ? m_perf[i] : 0); end
    end
    drive_idle();
  endtask

  task automatic test_perf();
    int grants = 0;
    int a;
    do_reset();
    bus.src_valid = 8'b0000_0100;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      a = m_lowest_alloc();
      bus.rsp_valid  = (a >= 0);
      bus.rsp_mshrid = (a >= 0) ? 8'(BASE + a) : 8'd0;
      model_cycle();
      if (obs_src_ready[2]) grants++;
    end
    bus.src_valid = '0; bus.rsp_valid = 1'b0;
    total++; if (grants != 10) begin bad++; $display("[TB] FAIL perf_grant_count got=%0d exp=10", grants); end
    for (int i = 0; i < N; i++) begin
      total++; if (perf_grants[i*32 +: 32] !== ((PERF_ON && i == 2) ? 32'd10 : 32'd0)) begin bad++; $display("[TB] FAIL perf_src src=%0d got=%0d exp=%0d", i, perf_grants[i*32 +: 32], (PERF_ON && i == 2) ? 10 : 0); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_idle();
    do_reset();
    test_reset();
    test_round_robin();
    test_pool_reuse();
    test_reset_mid_op();
    test_backpressure();
    test_max_out();
    test_stray();
    test_src_en();
    test_random();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
